// File: rtl/spi_rx_pkg.sv
// ----------------------------------------------------------------------------
// spi_rx_pkg
//   Shared types and defaults for the SPI word receiver.
//   spi_rx_state_t : receiver FSM state encoding
//   SPI_DATA_W     : default word width
//   SPI_SYNC_STAGES: default synchronizer depth
// ----------------------------------------------------------------------------
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } spi_rx_state_t;

    localparam int SPI_DATA_W      = 16;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_word_rx_sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
//   Multi-flop synchronizer for one asynchronous input plus edge detection
//   on the synchronized value.
//   Ports:
//     clk   in   system clock
//     rst_n in   asynchronous active-low reset
//     d     in   asynchronous input
//     q     out  synchronized input (last sync flop)
//     rise  out  q went 0 -> 1 this clk
//     fall  out  q went 1 -> 0 this clk
//   RST_VAL is loaded into every flop (including the edge-detect delay flop)
//   so the chain starts in the input's idle level.
// ----------------------------------------------------------------------------
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise =  q & ~dly_q;
    assign fall = ~q &  dly_q;

endmodule

// File: rtl/spi_word_rx.sv
// ----------------------------------------------------------------------------
// spi_word_rx
//   SPI slave word receiver running entirely on clk. cs_n, sclk and sdi are
//   oversampled through synchronizers; sdi is shifted in MSB first on each
//   detected sclk rising edge. When cs_n deasserts, the bit count decides
//   between a good word (rx_valid pulse) and a framing error (frame_err
//   pulse).
//   Ports:
//     clk       in   system clock, the only clock
//     rst_n     in   asynchronous active-low reset
//     cs_n      in   SPI chip select, active low, asynchronous
//     sclk      in   SPI clock, sampled only
//     sdi       in   SPI data, valid on sclk rising edge
//     rx_data   out  last good word, held until the next good frame
//     rx_valid  out  one-clk pulse, rx_data updated this cycle
//     frame_err out  one-clk pulse, frame ended with a bad bit count
//     busy      out  FSM is not IDLE
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for cs_n to fall; sclk edges ignored
//   SHIFT | frame open; shift sdi on sclk rise, count bits (saturating)
//   CHECK | one clk; judge bit count, issue rx_valid or frame_err
// ----------------------------------------------------------------------------
module spi_word_rx
    import spi_rx_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              sdi,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    // One past a full word: any overlong frame parks here instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W + 1);

    logic cs_s_unused;
    logic cs_rise;
    logic cs_fall;
    logic sclk_s_unused;
    logic sclk_rise;
    logic sclk_fall_unused;
    logic sdi_s;
    logic sdi_rise_unused;
    logic sdi_fall_unused;

    // cs_n idles high, so its chain resets high: if cs_n is still low when
    // reset releases, a cs_fall is produced and a (partial) frame opens.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (cs_s_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (sclk_s_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    // Same depth as the sclk chain so sdi_s is the value captured alongside
    // the sclk sample that produced sclk_rise.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_sdi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sdi),
        .q     (sdi_s),
        .rise  (sdi_rise_unused),
        .fall  (sdi_fall_unused)
    );

    spi_rx_state_t     state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    // A bit arriving with cs_rise is still shifted and counted.
                    if (sclk_rise) begin
                        shift_q <= {shift_q[DATA_W-2:0], sdi_s};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (cs_rise) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (bit_cnt_q == CNT_FULL) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    // A very short cs_n high gap can reopen the frame here.
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_word_rx.sv
module tb_spi_word_rx;

    localparam int DW = 16;
    localparam int SS = 2;
    localparam int PH = 5;   // sclk half period in clk cycles (20 ns clk -> 5 MHz sclk)

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic          sclk;
    logic          sdi;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    always #10 clk = ~clk;

    spi_word_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .sdi       (sdi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    int            valid_cnt      = 0;
    int            err_cnt        = 0;
    int            viol_cnt       = 0;
    int            busy_cycles    = 0;
    int            last_pulse_cyc = -1000;
    int            busy_rise_cyc  = -1000;
    logic          prev_v = 1'b0, prev_e = 1'b0, prev_b = 1'b0;
    logic [DW-1:0] valid_log [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                valid_cnt++;
                valid_log.push_back(rx_data);
                last_pulse_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt++;
                last_pulse_cyc = cyc;
            end
            if ((rx_valid && frame_err) || (rx_valid && prev_v) || (frame_err && prev_e))
                viol_cnt++;
            if (busy) busy_cycles++;
            if (busy && !prev_b) busy_rise_cyc = cyc;
        end
        prev_v = rx_valid;
        prev_e = frame_err;
        prev_b = busy;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- stimulus ----------------
    int cs_fall_cyc, cs_rise_cyc;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        sclk = 1'b0;
        cs_fall_cyc = cyc;
        tick(PH);
    endtask

    task automatic send_bit(input logic b);
        sdi  = b;
        sclk = 1'b0;
        tick(PH);
        sclk = 1'b1;
        tick(PH);
    endtask

    task automatic cs_high(input int gap);
        sclk = 1'b0;
        tick(PH);
        cs_n = 1'b1;
        cs_rise_cyc = cyc;
        tick(gap);
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits, input int gap);
        cs_low();
        for (int i = nbits - 1; i >= 0; i--) send_bit(data[i]);
        cs_high(gap);
    endtask

    typedef struct {
        logic [63:0]   data;
        int            nbits;
        logic          exp_valid;
        logic          exp_err;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t          vecs [6];
    logic [DW-1:0] model_data;
    int            v0, e0, b0, idx, bad, nb;
    int            nb_tab [7];
    logic [63:0]   rdata;
    logic [15:0]   beef;

    initial begin
        vecs[0] = '{64'hA5C3,         16, 1'b1, 1'b0, 16'hA5C3};
        vecs[1] = '{64'h1234,         16, 1'b1, 1'b0, 16'h1234};
        vecs[2] = '{64'h3FFF,         15, 1'b0, 1'b1, 16'h1234};
        vecs[3] = '{64'h1ABCD,        17, 1'b0, 1'b1, 16'h1234};
        vecs[4] = '{64'hDE_ADBE_EF01, 40, 1'b0, 1'b1, 16'h1234};
        vecs[5] = '{64'h0001,         16, 1'b1, 1'b0, 16'h0001};
        nb_tab  = '{14, 15, 16, 16, 16, 17, 19};

        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; sdi = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(3);
        check("reset rx_data",   64'(rx_data),   64'h0);
        check("reset rx_valid",  64'(rx_valid),  64'h0);
        check("reset frame_err", 64'(frame_err), 64'h0);
        check("reset busy",      64'(busy),      64'h0);

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt; e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].nbits, 12);
            check($sformatf("vec%0d valid_pulses", i), 64'(valid_cnt - v0), 64'(vecs[i].exp_valid));
            check($sformatf("vec%0d err_pulses", i),   64'(err_cnt - e0),   64'(vecs[i].exp_err));
            check($sformatf("vec%0d rx_data", i),      64'(rx_data),        64'(vecs[i].exp_data));
            check($sformatf("vec%0d busy_after", i),   64'(busy),           64'h0);
            if (i == 0) begin
                check("latency cs_rise->rx_valid", 64'(last_pulse_cyc - cs_rise_cyc), 64'(SS + 2));
                check("latency cs_fall->busy",     64'(busy_rise_cyc - cs_fall_cyc),  64'(SS + 1));
            end
        end
        model_data = 16'h0001;

        // random frames against the count-rule model
        for (int r = 0; r < 10; r++) begin
            nb    = nb_tab[$urandom_range(0, 6)];
            rdata = {$urandom, $urandom};
            v0 = valid_cnt; e0 = err_cnt;
            send_frame(rdata, nb, 12);
            if (nb == DW) model_data = rdata[DW-1:0];
            check($sformatf("rand%0d n=%0d valid_pulses", r, nb), 64'(valid_cnt - v0), 64'(nb == DW));
            check($sformatf("rand%0d n=%0d err_pulses", r, nb),   64'(err_cnt - e0),   64'(nb != DW));
            check($sformatf("rand%0d n=%0d rx_data", r, nb),      64'(rx_data),        64'(model_data));
        end

        // back-to-back, 3 clk cs_n high gap
        v0 = valid_cnt; e0 = err_cnt; idx = valid_log.size();
        send_frame(64'h0001, 16, 3);
        send_frame(64'hFFFF, 16, 12);
        check("b2b valid_pulses", 64'(valid_cnt - v0), 64'd2);
        check("b2b err_pulses",   64'(err_cnt - e0),   64'd0);
        if (valid_log.size() >= idx + 2) begin
            check("b2b first word",  64'(valid_log[idx]),     64'h0001);
            check("b2b second word", 64'(valid_log[idx + 1]), 64'hFFFF);
        end else begin
            check("b2b log size", 64'(valid_log.size() - idx), 64'd2);
        end

        // 1 clk cs_n high gap: second frame may be lost or flagged, never corrupt
        idx = valid_log.size();
        send_frame(64'h5A5A, 16, 1);
        send_frame(64'hC3C3, 16, 12);
        bad = 0;
        for (int k = idx; k < valid_log.size(); k++)
            if (valid_log[k] != 16'h5A5A && valid_log[k] != 16'hC3C3) bad++;
        check("gap1 corrupt words", 64'(bad), 64'd0);
        check("gap1 first word seen", 64'(valid_log.size() > idx && valid_log[idx] == 16'h5A5A), 64'd1);

        // reset mid-frame, released with cs_n still low
        beef = 16'hBEEF;
        cs_low();
        for (int i = 15; i >= 8; i--) send_bit(beef[i]);
        sclk  = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("midrst rx_data",   64'(rx_data),   64'h0);
        check("midrst rx_valid",  64'(rx_valid),  64'h0);
        check("midrst frame_err", 64'(frame_err), 64'h0);
        check("midrst busy",      64'(busy),      64'h0);
        v0 = valid_cnt; e0 = err_cnt;
        rst_n = 1'b1;
        model_data = '0;
        tick(6);
        check("midrst partial busy", 64'(busy), 64'h1);
        cs_high(12);
        check("midrst err_pulses",   64'(err_cnt - e0),   64'd1);
        check("midrst valid_pulses", 64'(valid_cnt - v0), 64'd0);
        check("midrst rx_data held", 64'(rx_data),        64'(model_data));
        v0 = valid_cnt;
        send_frame(64'hCAFE, 16, 12);
        model_data = 16'hCAFE;
        check("after rst valid_pulses", 64'(valid_cnt - v0), 64'd1);
        check("after rst rx_data",      64'(rx_data),        64'(model_data));

        // cs_n high with sclk toggling
        v0 = valid_cnt; e0 = err_cnt; b0 = busy_cycles;
        for (int k = 0; k < 32; k++) begin
            sdi  = 1'($urandom);
            sclk = 1'b1;
            tick(PH);
            sclk = 1'b0;
            tick(PH);
        end
        tick(8);
        check("idle sclk valid_pulses", 64'(valid_cnt - v0),   64'd0);
        check("idle sclk err_pulses",   64'(err_cnt - e0),     64'd0);
        check("idle sclk busy_cycles",  64'(busy_cycles - b0), 64'd0);
        check("idle sclk rx_data",      64'(rx_data),          64'(model_data));

        check("pulse rule violations", 64'(viol_cnt), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
